// File: rtl/ro_puf_sequencer_pkg.sv
// Shared types and default parameters for the RO-PUF challenge sequencer.
package ro_puf_sequencer_pkg;

  localparam int DEF_WINDOW = 16;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_CW     = 4;
  localparam int DEF_NCH    = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_puf_sequencer_if.sv
// Handshake and datapath signals between system logic, the counter block and the sequencer.
interface ro_puf_sequencer_if
  import ro_puf_sequencer_pkg::*;
#(
  parameter int CW  = DEF_CW,
  parameter int NCH = DEF_NCH
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           start;
  logic [CW-1:0]  count1;
  logic [CW-1:0]  count2;
  logic           en;
  logic           ctr_reset;
  logic [SW-1:0]  s;
  logic           busy;
  logic           done;
  logic           valid;
  logic [NCH-1:0] response;
  logic [NCH-1:0] tie;

  modport master (
    output start, count1, count2,
    input  en, ctr_reset, s, busy, done, valid, response, tie
  );

  modport slave (
    input  start, count1, count2,
    output en, ctr_reset, s, busy, done, valid, response, tie
  );

endinterface

// File: rtl/ro_window_timer.sv
// Loadable down-counter; expired is high once the loaded count has run down to zero.
module ro_window_timer #(
  parameter int TW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [TW-1:0] i_value,
  output logic          o_expired
);

  logic [TW-1:0] r_count;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {TW{1'b0}};
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != {TW{1'b0}}) begin
      r_count <= r_count - {{(TW-1){1'b0}}, 1'b1};
    end
  end

  assign o_expired = (r_count == {TW{1'b0}});

endmodule

// File: rtl/ro_puf_sequencer.sv
// RO-PUF challenge sweep controller: clear, enable window, settle and compare for every mux select.
module ro_puf_sequencer
  import ro_puf_sequencer_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CW     = DEF_CW,
  parameter int NCH    = DEF_NCH
) (
  input logic              i_clk,
  input logic              i_rst,
  ro_puf_sequencer_if.slave io_bus
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(max_int(WINDOW, SETTLE)) + 1;

  state_t         r_state;
  logic           r_en;
  logic           r_ctr_reset;
  logic [SW-1:0]  r_sel;
  logic           r_busy;
  logic           r_done;
  logic           r_valid;
  logic [NCH-1:0] r_response;
  logic [NCH-1:0] r_tie;
  logic [NCH-1:0] r_sh_resp;
  logic [NCH-1:0] r_sh_tie;

  logic [CW-1:0]  w_count1;
  logic [CW-1:0]  w_count2;
  logic           w_gt;
  logic           w_eq;
  logic [NCH-1:0] w_resp_next;
  logic [NCH-1:0] w_tie_next;
  logic           w_tmr_load;
  logic [TW-1:0]  w_tmr_value;
  logic           w_expired;

  assign w_count1 = io_bus.count1;
  assign w_count2 = io_bus.count2;
  assign w_gt     = (w_count2 > w_count1);
  assign w_eq     = (w_count2 == w_count1);

  // Shadow vectors with the current challenge's compare result merged in.
  always_comb begin
    w_resp_next        = r_sh_resp;
    w_tie_next         = r_sh_tie;
    w_resp_next[r_sel] = w_gt;
    w_tie_next[r_sel]  = w_eq;
  end

  // Timer reload: enable window on leaving CLEAR, settle window on leaving RUN.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = {TW{1'b0}};
    case (r_state)
      ST_CLEAR: begin
        w_tmr_load  = 1'b1;
        w_tmr_value = TW'(WINDOW - 1);
      end
      ST_RUN: begin
        if (w_expired) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = TW'(SETTLE - 1);
        end else begin
          w_tmr_load  = 1'b0;
          w_tmr_value = {TW{1'b0}};
        end
      end
      default: begin
        w_tmr_load  = 1'b0;
        w_tmr_value = {TW{1'b0}};
      end
    endcase
  end

  ro_window_timer #(.TW(TW)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_tmr_load),
    .i_value   (w_tmr_value),
    .o_expired (w_expired)
  );

  // Sweep FSM; every output is set on the edge that enters the state it belongs to.
  // FINISH samples start like IDLE so a held start yields back-to-back sweeps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_en        <= 1'b0;
      r_ctr_reset <= 1'b1;
      r_sel       <= {SW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_response  <= {NCH{1'b0}};
      r_tie       <= {NCH{1'b0}};
      r_sh_resp   <= {NCH{1'b0}};
      r_sh_tie    <= {NCH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE, ST_FINISH: begin
          r_done      <= 1'b0;
          r_en        <= 1'b0;
          r_ctr_reset <= 1'b1;
          if (io_bus.start) begin
            r_state   <= ST_CLEAR;
            r_sel     <= {SW{1'b0}};
            r_valid   <= 1'b0;
            r_busy    <= 1'b1;
            r_sh_resp <= {NCH{1'b0}};
            r_sh_tie  <= {NCH{1'b0}};
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_state     <= ST_RUN;
          r_ctr_reset <= 1'b0;
          r_en        <= 1'b1;
        end
        ST_RUN: begin
          if (w_expired) begin
            r_state <= ST_SETTLE;
            r_en    <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_expired) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_sh_resp <= w_resp_next;
          r_sh_tie  <= w_tie_next;
          if (r_sel == SW'(NCH - 1)) begin
            r_state    <= ST_FINISH;
            r_response <= w_resp_next;
            r_tie      <= w_tie_next;
            r_done     <= 1'b1;
            r_valid    <= 1'b1;
          end else begin
            r_state     <= ST_CLEAR;
            r_sel       <= r_sel + SW'(1);
            r_ctr_reset <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_en        <= 1'b0;
          r_ctr_reset <= 1'b1;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.en        = r_en;
  assign io_bus.ctr_reset = r_ctr_reset;
  assign io_bus.s         = r_sel;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.valid     = r_valid;
  assign io_bus.response  = r_response;
  assign io_bus.tie       = r_tie;

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Self-checking bench for ro_puf_sequencer: schedule model, table sweeps, corner sequences, random sweeps.
module tb_ro_puf_sequencer;
  import ro_puf_sequencer_pkg::*;

  localparam int PER   = 20;  // 1 clear + 16 window + 2 settle + 1 capture
  localparam int SWEEP = 81;  // 4 challenges plus the finish cycle

  typedef struct packed {
    logic [15:0] c1;    // nibble i = count1 for challenge i
    logic [15:0] c2;
    logic [3:0]  resp;
    logic [3:0]  tie;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  int         m_t;
  logic [1:0] m_sel;
  logic       m_valid;
  logic [3:0] m_resp;
  logic [3:0] m_tie;
  logic [3:0] plan_c1 [4];
  logic [3:0] plan_c2 [4];
  vec_t       vecs [4];

  int sw_ndone, sw_done_at, sw_en_cnt, sw_clr_cnt;

  ro_puf_sequencer_if #(.CW(4), .NCH(4)) bus ();

  ro_puf_sequencer #(.WINDOW(16), .SETTLE(2), .CW(4), .NCH(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_sel = 2'd0; m_valid = 1'b0; m_resp = 4'd0; m_tie = 4'd0;
  endtask

  task automatic load_plan(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      plan_c1[i] = v.c1[4*i +: 4];
      plan_c2[i] = v.c2[4*i +: 4];
    end
  endtask

  // Advance the schedule model over one rising edge given the start level seen there.
  task automatic model_step(input logic st);
    if ((m_t == 0 || m_t == SWEEP) && st) begin
      m_t = 1; m_valid = 1'b0;
    end else if (m_t == SWEEP) begin
      m_t = 0;
    end else if (m_t != 0) begin
      m_t = m_t + 1;
    end
    if (m_t >= 1 && m_t < SWEEP) m_sel = 2'((m_t - 1) / PER);
    if (m_t == SWEEP) begin
      for (int i = 0; i < 4; i++) begin
        m_resp[i] = (plan_c2[i] > plan_c1[i]);
        m_tie[i]  = (plan_c2[i] == plan_c1[i]);
      end
      m_valid = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int p;
    logic e_en, e_ctr;
    p     = (m_t >= 1) ? (m_t - 1) % PER : 0;
    e_en  = (m_t >= 1 && m_t < SWEEP && p >= 1 && p <= 16);
    e_ctr = (m_t == 0) || (m_t < SWEEP && p == 0);
    chk("en",        32'(bus.en),        32'(e_en));
    chk("ctr_reset", 32'(bus.ctr_reset), 32'(e_ctr));
    chk("s",         32'(bus.s),         32'(m_sel));
    chk("busy",      32'(bus.busy),      32'(m_t != 0));
    chk("done",      32'(bus.done),      32'(m_t == SWEEP));
    chk("valid",     32'(bus.valid),     32'(m_valid));
    chk("response",  32'(bus.response),  32'(m_resp));
    chk("tie",       32'(bus.tie),       32'(m_tie));
  endtask

  // One clock: drive inputs, take the edge, update the model, compare on the falling edge.
  task automatic cycle(input logic st);
    int c, p;
    c = (m_t >= 1 && m_t < SWEEP) ? (m_t - 1) / PER : 0;
    p = (m_t >= 1 && m_t < SWEEP) ? (m_t - 1) % PER : 0;
    bus.start = st;
    if (m_t >= 1 && m_t < SWEEP && p == PER - 1) begin
      bus.count1 = plan_c1[c];
      bus.count2 = plan_c2[c];
    end else begin
      bus.count1 = 4'($urandom_range(0, 15));
      bus.count2 = 4'($urandom_range(0, 15));
    end
    @(posedge clk);
    model_step(st);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  // Start a sweep from idle, optionally pulsing start again at two points, and return to idle.
  task automatic run_sweep(input int pa, input int pb);
    sw_ndone = 0; sw_done_at = -1; sw_en_cnt = 0; sw_clr_cnt = 0;
    for (int i = 0; i <= SWEEP; i++) begin
      cycle((i == 0) || (i == pa) || (i == pb));
      if (bus.done) begin sw_ndone++; sw_done_at = i + 1; end
      if (bus.en) sw_en_cnt++;
      if (bus.ctr_reset && bus.busy) sw_clr_cnt++;
    end
  endtask

  task automatic check_sweep_shape(input string tag);
    chk({tag, "_done_count"}, 32'(sw_ndone),   32'd1);
    chk({tag, "_done_cycle"}, 32'(sw_done_at), 32'd81);
    chk({tag, "_en_cycles"},  32'(sw_en_cnt),  32'd64);
    chk({tag, "_clr_pulses"}, 32'(sw_clr_cnt), 32'd4);
  endtask

  initial begin
    int d1, d2, nd;
    vec_t rv;
    vecs[0] = '{c1: {4'd0, 4'd7, 4'd9, 4'd5},    c2: {4'd15, 4'd7, 4'd5, 4'd9}, resp: 4'b1001, tie: 4'b0100};
    vecs[1] = '{c1: {4'd3, 4'd3, 4'd3, 4'd3},    c2: {4'd3, 4'd3, 4'd3, 4'd3},  resp: 4'b0000, tie: 4'b1111};
    vecs[2] = '{c1: {4'd14, 4'd15, 4'd0, 4'd0},  c2: {4'd15, 4'd0, 4'd1, 4'd15}, resp: 4'b1011, tie: 4'b0000};
    vecs[3] = '{c1: {4'd6, 4'd1, 4'd8, 4'd15},   c2: {4'd6, 4'd2, 4'd7, 4'd15}, resp: 4'b0100, tie: 4'b1001};

    bus.start = 1'b0; bus.count1 = 4'd0; bus.count2 = 4'd0;
    model_reset();
    load_plan(vecs[0]);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    repeat (10) cycle(1'b0);

    // Table-driven sweeps.
    for (int v = 0; v < 4; v++) begin
      load_plan(vecs[v]);
      run_sweep(-1, -1);
      check_sweep_shape("table");
      chk("table_response", 32'(bus.response), 32'(vecs[v].resp));
      chk("table_tie",      32'(bus.tie),      32'(vecs[v].tie));
      chk("table_valid",    32'(bus.valid),    32'd1);
    end

    // Start pulses mid-sweep are ignored.
    load_plan(vecs[3]);
    run_sweep(5, 40);
    check_sweep_shape("ignored_start");

    // Asynchronous reset in cycle 30 of a sweep.
    load_plan(vecs[0]);
    cycle(1'b1);
    repeat (29) cycle(1'b0);
    rst = 1'b1;
    #1;
    chk("rst_en",       32'(bus.en),        32'd0);
    chk("rst_busy",     32'(bus.busy),      32'd0);
    chk("rst_valid",    32'(bus.valid),     32'd0);
    chk("rst_ctr",      32'(bus.ctr_reset), 32'd1);
    chk("rst_response", 32'(bus.response),  32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    run_sweep(-1, -1);
    check_sweep_shape("after_reset");

    // Start held high: back-to-back sweeps.
    load_plan(vecs[2]);
    d1 = -1; d2 = -1; nd = 0;
    for (int i = 1; i <= 2 * SWEEP + 1; i++) begin
      cycle(i <= 2 * SWEEP);
      if (bus.done) begin
        nd++;
        if (d1 < 0) d1 = i; else d2 = i;
      end
    end
    chk("held_done_count",  32'(nd), 32'd2);
    chk("held_first_done",  32'(d1), 32'd81);
    chk("held_second_done", 32'(d2), 32'd162);

    // Random sweeps against the model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) begin
        rv.c1[4*i +: 4] = 4'($urandom_range(0, 15));
        rv.c2[4*i +: 4] = ($urandom_range(0, 3) == 0) ? rv.c1[4*i +: 4] : 4'($urandom_range(0, 15));
      end
      rv.resp = 4'd0; rv.tie = 4'd0;
      load_plan(rv);
      repeat ($urandom_range(0, 5)) cycle(1'b0);
      run_sweep($urandom_range(2, 79), $urandom_range(2, 79));
      check_sweep_shape("random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ro_puf_sequencer.md
# ro_puf_sequencer

Controller that runs a full RO-PUF challenge sweep over the ring-oscillator array. For each mux select value it clears the pair counters, opens a fixed enable window for the oscillators, waits for the counts to settle, then compares the two pair counts into one response bit. It sits between system logic (start/done handshake) and the oscillator/mux/counter datapath: it drives `en`, `S` and the counter clear, and reads `count1`/`count2`.

## Interface
- `WINDOW`, 16, clk cycles the oscillators stay enabled per challenge (≥1)
- `SETTLE`, 2, clk cycles after disable before counts are sampled (≥1)
- `CW`, 4, counter width of `count1`/`count2`
- `NCH`, 4, challenges per sweep; `S` width is log2(NCH)
- `clk` in 1: single system clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: request a sweep; sampled only in IDLE
- `count1` in CW: pair-A oscillation count from the counter block
- `count2` in CW: pair-B oscillation count from the counter block
- `en` out 1: oscillator enable
- `ctr_reset` out 1: counter clear, active-high
- `S` out log2(NCH): mux select (challenge index)
- `busy` out 1: sweep in progress
- `done` out 1: one-cycle pulse at sweep end
- `valid` out 1: `response` holds a completed sweep
- `response` out NCH: bit i = (count2 > count1) for challenge i
- `tie` out NCH: bit i = (count2 == count1) for challenge i

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, CAPTURE, FINISH.
- IDLE: `start`=1 → CLEAR, `S`←0, `valid`←0, clear internal response/tie shadow.
- CLEAR (1 cycle): `ctr_reset`=1, `en`=0 → RUN.
- RUN (WINDOW cycles): `en`=1 → SETTLE.
- SETTLE (SETTLE cycles): `en`=0; counts frozen → CAPTURE.
- CAPTURE (1 cycle): shadow bit[S] ← count2 > count1 (unsigned, CW-bit); tie bit[S] ← count2 == count1. If S == NCH-1 → FINISH, else S←S+1, → CLEAR.
- FINISH (1 cycle): `response`/`tie` ← shadow, `done`=1, `valid`←1 → IDLE.
- `busy`=1 in every state except IDLE.
- `start` outside IDLE ignored; not queued. `start` held high in IDLE after FINISH begins a new sweep immediately.
- Counter wrap: comparison is on raw CW-bit values; wrap is the datapath's concern, no saturation here.
- Tie resolves response bit to 0 with tie bit set.

## Timing
- Reset values: `en`=0, `ctr_reset`=1 (counters held clear while in reset and IDLE), `S`=0, `busy`=0, `done`=0, `valid`=0, `response`=0, `tie`=0. State = IDLE.
- `ctr_reset` is 1 in IDLE and CLEAR, 0 otherwise.
- All outputs registered; change only on `clk` rising edge (except async reset).
- Per challenge: 1 + WINDOW + SETTLE + 1 cycles. Sweep: NCH×(WINDOW+SETTLE+2) cycles, then FINISH cycle.
- Defaults: start sampled at edge 0 → CLEAR in cycle 1; `done` asserted in cycle 81.
- `response`/`tie` stable from FINISH until the FINISH of the next sweep; `valid` drops the cycle after a new `start` is accepted.
- Reset mid-sweep: immediate return to IDLE, `en`=0, partial results discarded, `valid`=0.

## Structure
- Shared package: state enum (6 states), default WINDOW/SETTLE/CW/NCH constants.
- One sub-module: `ro_window_timer` — loadable down-counter (width ≥ clog2(max(WINDOW,SETTLE))+1) with `load`, `value`, `expired`; reused for RUN and SETTLE.
- Remainder (FSM, challenge index, shadow registers, compare) in the top.

## Test plan
- Reset then idle 10 cycles → `en`=0, `ctr_reset`=1, `busy`=0, all result outputs 0.
- Start; counts model (count1,count2) = (5,9),(9,5),(7,7),(0,15) for S=0..3 → `done` at cycle 81, `response`=4'b1001, `tie`=4'b0100, `valid`=1.
- Check per challenge: `en` high exactly 16 cycles, `ctr_reset` pulse 1 cycle before each window, `S` steps 0→1→2→3.
- `start` pulsed at cycles 5 and 40 during a sweep → ignored; single `done`, timing unchanged.
- Assert `reset` at cycle 30 → `en`=0, `busy`=0, `valid`=0 same cycle; new start yields full 81-cycle sweep.
- `start` held high continuously → back-to-back sweeps, `done` at cycles 81 and 162, `valid` low between accept and second FINISH.
